// File: rtl/nvme_admin_db_sched_pkg.sv
// Shared types and constants for the admin doorbell scheduler.
package nvme_pkg;

    localparam logic [63:0] SQ0TDBL_OFF = 64'h0000_0000_0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } db_state_e;

    typedef enum logic {
        GNT_SQ = 1'b0,
        GNT_CQ = 1'b1
    } db_gnt_e;

    // Distance between consecutive doorbell registers for a given CAP.DSTRD.
    function automatic logic [63:0] db_stride(input int unsigned dstrd);
        return 64'(4) << dstrd;
    endfunction

endpackage

// File: rtl/nvme_admin_db_sched_if.sv
// Pointer/doorbell signal bundle between the queue logic, the scheduler and the doorbell writer.
interface nvme_admin_db_sched_if #(
    parameter int unsigned PTR_W = 4
);
    import nvme_pkg::*;

    logic             enable;
    logic             sq_push;
    logic [PTR_W-1:0] sq_tail;
    logic             sq_full;
    logic             sq_overflow;
    logic             cq_pop;
    logic [PTR_W-1:0] cq_sq_head;
    logic [PTR_W-1:0] cq_head;
    logic             cq_phase;
    logic             db_req;
    logic [63:0]      db_addr;
    logic [31:0]      db_data;
    logic             db_done;
    logic             busy;

    modport slave (
        input  enable, sq_push, cq_pop, cq_sq_head, db_done,
        output sq_tail, sq_full, sq_overflow, cq_head, cq_phase, db_req, db_addr, db_data, busy
    );

    modport master (
        output enable, sq_push, cq_pop, cq_sq_head, db_done,
        input  sq_tail, sq_full, sq_overflow, cq_head, cq_phase, db_req, db_addr, db_data, busy
    );

endinterface

// File: rtl/nvme_qptr.sv
// Queue pointer wrapping at QDEPTH-1 by explicit compare, with an optional phase tag that
// toggles on each wrap.
module nvme_qptr
    import nvme_pkg::*;
#(
    parameter int unsigned QDEPTH    = 16,
    parameter int unsigned PTR_W     = 4,
    parameter bit          HAS_PHASE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W-1:0] o_ptr_nxt,
    output logic             o_phase
);

    localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(QDEPTH - 1);

    logic [PTR_W-1:0] r_ptr;
    logic             r_phase;
    logic             w_wrap;

    assign w_wrap    = (r_ptr == LP_LAST);
    assign o_ptr_nxt = w_wrap ? '0 : r_ptr + PTR_W'(1);
    assign o_ptr     = r_ptr;
    assign o_phase   = r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_phase <= 1'b1;
        end else if (i_inc) begin
            r_ptr <= o_ptr_nxt;
            if (HAS_PHASE && w_wrap) begin
                r_phase <= ~r_phase;
            end
        end
    end

endmodule

// File: rtl/nvme_admin_db_sched.sv
// Admin SQ-tail / CQ-head owner: coalesces pointer movement into doorbell writes and
// round-robins the two doorbells onto a single req/done MMIO write engine.
module nvme_admin_db_sched
    import nvme_pkg::*;
#(
    parameter int unsigned QDEPTH    = 16,
    parameter int unsigned PTR_W     = 4,
    parameter logic [63:0] BAR0_BASE = 64'h0000_0000_0000_0000,
    parameter int unsigned DSTRD     = 0
) (
    input logic                  user_clk,
    input logic                  user_reset_n,
    nvme_admin_db_sched_if.slave db_if
);

    localparam logic [63:0] LP_SQ_DB = BAR0_BASE + SQ0TDBL_OFF;
    localparam logic [63:0] LP_CQ_DB = LP_SQ_DB + db_stride(DSTRD);

    logic [PTR_W-1:0] w_sq_tail;
    logic [PTR_W-1:0] w_sq_tail_nxt;
    logic [PTR_W-1:0] w_cq_head;
    logic [PTR_W-1:0] w_cq_nxt_unused;
    logic             w_cq_phase;
    logic             w_sq_phase_unused;
    logic             w_sq_full;
    logic             w_sq_inc;
    logic             w_issue_go;
    db_gnt_e          w_tgt;
    db_state_e        w_state_nxt;

    db_state_e        r_state;
    db_gnt_e          r_last_grant;
    logic [PTR_W-1:0] r_sq_head_shadow;
    logic             r_sq_dirty;
    logic             r_cq_dirty;
    logic             r_sq_overflow;
    logic [63:0]      r_db_addr;
    logic [31:0]      r_db_data;

    assign w_sq_full = (w_sq_tail_nxt == r_sq_head_shadow);
    assign w_sq_inc  = db_if.sq_push & ~w_sq_full;

    nvme_qptr #(.QDEPTH(QDEPTH), .PTR_W(PTR_W), .HAS_PHASE(1'b0)) u_sq_tail (
        .i_clk     (user_clk),
        .i_rst_n   (user_reset_n),
        .i_inc     (w_sq_inc),
        .o_ptr     (w_sq_tail),
        .o_ptr_nxt (w_sq_tail_nxt),
        .o_phase   (w_sq_phase_unused)
    );

    nvme_qptr #(.QDEPTH(QDEPTH), .PTR_W(PTR_W), .HAS_PHASE(1'b1)) u_cq_head (
        .i_clk     (user_clk),
        .i_rst_n   (user_reset_n),
        .i_inc     (db_if.cq_pop),
        .o_ptr     (w_cq_head),
        .o_ptr_nxt (w_cq_nxt_unused),
        .o_phase   (w_cq_phase)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue_go  = 1'b0;
        w_tgt       = (r_last_grant == GNT_SQ) ? GNT_CQ : GNT_SQ;
        if (!r_cq_dirty) begin
            w_tgt = GNT_SQ;
        end else if (!r_sq_dirty) begin
            w_tgt = GNT_CQ;
        end
        unique case (r_state)
            IDLE: begin
                if (db_if.enable && (r_sq_dirty || r_cq_dirty)) begin
                    w_issue_go  = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (db_if.db_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Dirty is cleared when the doorbell value is captured; a pointer move in that same cycle
    // re-arms it so the newer value goes out in a later doorbell.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state          <= IDLE;
            r_last_grant     <= GNT_CQ;
            r_sq_head_shadow <= '0;
            r_sq_dirty       <= 1'b0;
            r_cq_dirty       <= 1'b0;
            r_sq_overflow    <= 1'b0;
            r_db_addr        <= '0;
            r_db_data        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sq_dirty <= w_sq_inc | (r_sq_dirty & ~(w_issue_go & (w_tgt == GNT_SQ)));
            r_cq_dirty <= db_if.cq_pop | (r_cq_dirty & ~(w_issue_go & (w_tgt == GNT_CQ)));
            if (w_issue_go) begin
                r_last_grant <= w_tgt;
                r_db_addr    <= (w_tgt == GNT_SQ) ? LP_SQ_DB : LP_CQ_DB;
                r_db_data    <= (w_tgt == GNT_SQ) ? 32'(w_sq_tail) : 32'(w_cq_head);
            end
            if (db_if.cq_pop) begin
                r_sq_head_shadow <= db_if.cq_sq_head;
            end
            if (db_if.sq_push && w_sq_full) begin
                r_sq_overflow <= 1'b1;
            end
        end
    end

    assign db_if.sq_tail     = w_sq_tail;
    assign db_if.sq_full     = w_sq_full;
    assign db_if.sq_overflow = r_sq_overflow;
    assign db_if.cq_head     = w_cq_head;
    assign db_if.cq_phase    = w_cq_phase;
    assign db_if.db_req      = (r_state == ISSUE);
    assign db_if.db_addr     = r_db_addr;
    assign db_if.db_data     = r_db_data;
    assign db_if.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_nvme_admin_db_sched.sv
// Scoreboard bench: a transaction-level model predicts every doorbell and pointer state;
// a negedge monitor compares the DUT against it while directed and random stimulus runs.
module tb_nvme_admin_db_sched;

    localparam int unsigned QDEPTH = 16;
    localparam int unsigned PTR_W  = 4;
    localparam logic [63:0] SQ_DB  = 64'h1000;
    localparam logic [63:0] CQ_DB  = 64'h1004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nvme_admin_db_sched_if #(.PTR_W(PTR_W)) bus ();

    nvme_admin_db_sched #(
        .QDEPTH    (QDEPTH),
        .PTR_W     (PTR_W),
        .BAR0_BASE (64'h0),
        .DSTRD     (0)
    ) dut (
        .user_clk     (clk),
        .user_reset_n (rst_n),
        .db_if        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [63:0] addr;
        logic [31:0] data;
    } db_t;

    db_t exp_q[$];
    int  cyc = 0;
    int  m_sq_tail, m_cq_head, m_shadow, m_last, m_eng;  // m_eng: 0 free, 1 requesting, 2 waiting
    bit  m_phase, m_ovf, m_sqd, m_cqd;

    function automatic int wrap_inc(int p);
        return (p == int'(QDEPTH) - 1) ? 0 : p + 1;
    endfunction

    function automatic void model_reset();
        m_sq_tail = 0; m_cq_head = 0; m_shadow = 0;
        m_last = 1; m_eng = 0;
        m_phase = 1'b1; m_ovf = 1'b0; m_sqd = 1'b0; m_cqd = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_step(bit push, bit pop, int sh, bit en, bit done);
        bit  full;
        bit  pick_sq;
        db_t e;
        full = (wrap_inc(m_sq_tail) == m_shadow);
        if (m_eng == 1) begin
            m_eng = 2;
        end else if (m_eng == 2) begin
            if (done) m_eng = 0;
        end else if (en && (m_sqd || m_cqd)) begin
            pick_sq = m_sqd && (!m_cqd || m_last == 1);
            e.cyc  = cyc;
            e.addr = pick_sq ? SQ_DB : CQ_DB;
            e.data = pick_sq ? 32'(m_sq_tail) : 32'(m_cq_head);
            exp_q.push_back(e);
            if (pick_sq) m_sqd = 1'b0; else m_cqd = 1'b0;
            m_last = pick_sq ? 0 : 1;
            m_eng  = 1;
        end
        if (push) begin
            if (full) m_ovf = 1'b1;
            else begin m_sq_tail = wrap_inc(m_sq_tail); m_sqd = 1'b1; end
        end
        if (pop) begin
            if (m_cq_head == int'(QDEPTH) - 1) m_phase = ~m_phase;
            m_cq_head = wrap_inc(m_cq_head);
            m_shadow  = sh;
            m_cqd     = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            model_step(bus.sq_push, bus.cq_pop, int'(bus.cq_sq_head), bus.enable, bus.db_done);
        end
    end

    // ---------------- monitor ----------------
    logic [63:0] hold_addr = '0;
    logic [31:0] hold_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_req;
            exp_req = 1'b0;
            if (exp_q.size() > 0) exp_req = (exp_q[0].cyc == cyc);
            chk("db_req", bus.db_req, exp_req);
            if (exp_req) begin
                chk("db_addr", bus.db_addr, exp_q[0].addr);
                chk("db_data", bus.db_data, exp_q[0].data);
                hold_addr = exp_q[0].addr;
                hold_data = exp_q[0].data;
                void'(exp_q.pop_front());
            end else if (m_eng == 2) begin
                chk("hold_addr", bus.db_addr, hold_addr);
                chk("hold_data", bus.db_data, hold_data);
            end
            chk("sq_tail", bus.sq_tail, m_sq_tail);
            chk("cq_head", bus.cq_head, m_cq_head);
            chk("cq_phase", bus.cq_phase, m_phase);
            chk("sq_full", bus.sq_full, wrap_inc(m_sq_tail) == m_shadow);
            chk("sq_overflow", bus.sq_overflow, m_ovf);
            chk("busy", bus.busy, m_eng != 0);
        end
    end

    // ---------------- driver / doorbell responder ----------------
    int          done_wait = 0;
    bit          auto_done = 1'b1;
    bit          spurious  = 1'b0;
    int          log_n     = 0;
    logic [63:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [63:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic tick();
        @(negedge clk);
        bus.sq_push = 1'b0;
        bus.cq_pop  = 1'b0;
        bus.db_done = 1'b0;
        if (!rst_n) begin
            done_wait = 0;
        end else if (bus.db_req) begin
            log_addr.push_back(bus.db_addr);
            log_data.push_back(bus.db_data);
            last_addr = bus.db_addr;
            last_data = bus.db_data;
            done_wait = $urandom_range(1, 4);
        end else if (done_wait > 0) begin
            done_wait--;
            if (done_wait == 0 && auto_done) bus.db_done = 1'b1;
        end
        if (spurious && $urandom_range(0, 15) == 0) bus.db_done = 1'b1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.sq_push    = 1'b0;
        bus.cq_pop     = 1'b0;
        bus.cq_sq_head = '0;
        bus.db_done    = 1'b0;
        repeat (3) tick();
        #1;
        chk("rst0_cq_phase", bus.cq_phase, 1);
        chk("rst0_busy", bus.busy, 0);
        chk("rst0_db_req", bus.db_req, 0);
        rst_n = 1'b1;

        // Reset asserted while a doorbell is outstanding.
        bus.enable = 1'b1;
        auto_done  = 1'b0;
        bus.sq_push = 1'b1;
        repeat (4) tick();
        chk("prerst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sq_tail", bus.sq_tail, 0);
        chk("rst_cq_head", bus.cq_head, 0);
        chk("rst_cq_phase", bus.cq_phase, 1);
        chk("rst_sq_full", bus.sq_full, 0);
        chk("rst_sq_ovf", bus.sq_overflow, 0);
        chk("rst_db_req", bus.db_req, 0);
        chk("rst_db_addr", bus.db_addr, 0);
        chk("rst_db_data", bus.db_data, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_log();
        repeat (6) tick();
        chk("rst_no_req", log_addr.size(), 0);

        // Coalescing with db_done held low.
        bus.sq_push = 1'b1; tick();
        bus.sq_push = 1'b1; tick();
        bus.sq_push = 1'b1; tick();
        repeat (5) tick();
        chk("coal_n1", log_addr.size(), 1);
        chk("coal_addr1", log_addr[0], SQ_DB);
        chk("coal_data1", log_data[0], 1);
        bus.db_done = 1'b1;
        repeat (5) tick();
        chk("coal_n2", log_addr.size(), 2);
        chk("coal_addr2", log_addr[1], SQ_DB);
        chk("coal_data2", log_data[1], 3);
        repeat (6) tick();
        chk("coal_total", log_addr.size(), 2);
        bus.db_done = 1'b1;
        tick();
        auto_done = 1'b1;

        // Arbitration: SQ wins the first tie, then alternates.
        do_reset();
        bus.sq_push = 1'b1; bus.cq_pop = 1'b1; bus.cq_sq_head = '0;
        repeat (16) tick();
        chk("arb_n", log_addr.size(), 2);
        chk("arb_a0", log_addr[0], SQ_DB);
        chk("arb_d0", log_data[0], 1);
        chk("arb_a1", log_addr[1], CQ_DB);
        chk("arb_d1", log_data[1], 1);
        bus.sq_push = 1'b1; bus.cq_pop = 1'b1; bus.cq_sq_head = '0;
        repeat (16) tick();
        chk("arb_n2", log_addr.size(), 4);
        chk("arb_a2", log_addr[2], SQ_DB);
        chk("arb_d2", log_data[2], 2);
        chk("arb_a3", log_addr[3], CQ_DB);
        chk("arb_d3", log_data[3], 2);

        // CQ wrap toggles the phase.
        do_reset();
        repeat (QDEPTH) begin
            bus.cq_pop = 1'b1; bus.cq_sq_head = '0;
            tick();
        end
        repeat (20) tick();
        chk("cqw_head", bus.cq_head, 0);
        chk("cqw_phase", bus.cq_phase, 0);
        chk("cqw_addr", last_addr, CQ_DB);
        chk("cqw_data", last_data, 0);

        // SQ full / overflow.
        bus.enable = 1'b0;
        do_reset();
        repeat (QDEPTH - 1) begin
            bus.sq_push = 1'b1;
            tick();
        end
        chk("full_tail", bus.sq_tail, 15);
        chk("full_flag", bus.sq_full, 1);
        chk("full_ovf0", bus.sq_overflow, 0);
        bus.sq_push = 1'b1;
        tick();
        chk("ovf_tail", bus.sq_tail, 15);
        chk("ovf_flag", bus.sq_overflow, 1);
        bus.cq_pop = 1'b1; bus.cq_sq_head = PTR_W'(5);
        tick();
        chk("unfull", bus.sq_full, 0);
        chk("ovf_sticky", bus.sq_overflow, 1);

        // Enable gating.
        do_reset();
        repeat (4) begin
            bus.sq_push = 1'b1;
            tick();
        end
        repeat (5) tick();
        chk("gate_none", log_addr.size(), 0);
        bus.enable = 1'b1;
        tick();
        tick();
        chk("gate_n", log_addr.size(), 1);
        chk("gate_addr", log_addr[0], SQ_DB);
        chk("gate_data", log_data[0], 4);

        // Randomized traffic with enable toggling and stray db_done pulses.
        repeat (20) tick();
        do_reset();
        spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
            bus.sq_push    = ($urandom_range(0, 3) == 0);
            bus.cq_pop     = ($urandom_range(0, 4) == 0);
            bus.cq_sq_head = PTR_W'($urandom_range(0, QDEPTH - 1));
            tick();
        end
        spurious   = 1'b0;
        bus.enable = 1'b1;
        repeat (40) tick();
        chk("drain_q", exp_q.size(), 0);
        chk("drain_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
